// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART register-access path.
package uart_pkg;

    // Command engine states.
    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        WRITE_REG,
        READ_REQ,
        READ_CAP,
        TRANSMIT
    } cmd_state_t;

    // Byte returned in place of read data when the address is out of range.
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    // Command byte bit that selects write (1) or read (0).
    localparam int CMD_WR_BIT = 0;

endpackage

// File: rtl/cmd_timeout_timer.sv
// cmd_timeout_timer: down-counter that flags when TIMEOUT cycles pass without a clear.
// Reloads on clear, counts while enabled, and asserts expired on the cycle the
// idle run reaches TIMEOUT-1 so the owner can register its pulse on that edge.
module cmd_timeout_timer
    import uart_pkg::*;
#(
    parameter int TIMEOUT = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Reload on clear, otherwise count down towards zero while enabled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = enable && !clear && (count <= CNT_W'(1));

endmodule

// File: rtl/reg_cmd_engine.sv
// reg_cmd_engine: UART register-access engine.
// Decodes command bytes from RX, assembles little-endian write words, issues
// one-cycle read/write strobes and streams read data back to TX LSB first.
module reg_cmd_engine
    import uart_pkg::*;
#(
    parameter int DATA_BYTES = 1,
    parameter int ADDR_W     = 3,
    parameter int NUM_REGS   = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_data_valid,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_data_valid,
    input  logic                    i_tx_ready,
    output logic [ADDR_W-1:0]       o_rwaddr,
    output logic                    o_rd_req,
    output logic                    o_wr_req,
    output logic [8*DATA_BYTES-1:0] o_write_reg,
    input  logic [8*DATA_BYTES-1:0] i_read_reg,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam int               DATA_W    = 8 * DATA_BYTES;
    localparam int               CNT_W     = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(DATA_BYTES - 1);

    cmd_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              in_range;
    logic              err_tx;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] wdata_next;
    // Holds the read word shifted down one lane; lane 0 goes straight to o_tx_data.
    logic [DATA_W-1:0] tx_shift;
    logic [7:0]        tx_next_byte;

    logic cmd_in_range;
    logic cmd_is_write;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    assign cmd_in_range = int'(i_rx_data[7:1]) < NUM_REGS;
    assign cmd_is_write = i_rx_data[CMD_WR_BIT];

    // Merge the incoming byte into its lane and pick the next TX byte.
    always_comb begin
        // NOTE: default assignment first so no path leaves wdata_next unassigned (no latch).
        wdata_next = wdata;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (cnt == CNT_W'(i)) begin
                wdata_next[8*i +: 8] = i_rx_data;
            end
        end
        tx_next_byte = 8'(tx_shift >> (8 * int'(cnt)));
    end

    // The idle timer restarts on write-command entry and on every data byte.
    assign timer_en    = (state == GET_DATA);
    assign timer_clear = i_rx_data_valid &&
                         (((state == IDLE) && cmd_is_write) || (state == GET_DATA));

    if (TIMEOUT > 0) begin : g_timer
        cmd_timeout_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .clear   (timer_clear),
            .enable  (timer_en),
            .expired (timer_expired)
        );
    end else begin : g_no_timer
        logic unused_timer;
        assign unused_timer  = timer_clear ^ timer_en;
        assign timer_expired = 1'b0;
    end

    // Command FSM with registered strobes, address, write word and TX byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            cnt             <= '0;
            in_range        <= 1'b0;
            err_tx          <= 1'b0;
            wdata           <= '0;
            tx_shift        <= '0;
            o_tx_data       <= '0;
            o_tx_data_valid <= 1'b0;
            o_rwaddr        <= '0;
            o_rd_req        <= 1'b0;
            o_wr_req        <= 1'b0;
            o_write_reg     <= '0;
            o_busy          <= 1'b0;
            o_timeout       <= 1'b0;
        end else begin
            o_rd_req  <= 1'b0;
            o_wr_req  <= 1'b0;
            o_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_rx_data_valid) begin
                        o_rwaddr <= i_rx_data[ADDR_W:1];
                        in_range <= cmd_in_range;
                        cnt      <= '0;
                        o_busy   <= 1'b1;
                        if (cmd_is_write) begin
                            state <= GET_DATA;
                        end else if (cmd_in_range) begin
                            o_rd_req <= 1'b1;
                            state    <= READ_REQ;
                        end else begin
                            err_tx          <= 1'b1;
                            o_tx_data       <= ERR_BYTE;
                            o_tx_data_valid <= 1'b1;
                            state           <= TRANSMIT;
                        end
                    end
                end

                GET_DATA: begin
                    if (i_rx_data_valid) begin
                        wdata <= wdata_next;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == LAST_LANE) begin
                            state <= WRITE_REG;
                            if (in_range) begin
                                o_wr_req    <= 1'b1;
                                o_write_reg <= wdata_next;
                            end
                        end
                    end else if (timer_expired) begin
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end
                end

                WRITE_REG: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                READ_REQ: begin
                    state <= READ_CAP;
                end

                READ_CAP: begin
                    tx_shift        <= i_read_reg >> 8;
                    o_tx_data       <= i_read_reg[7:0];
                    o_tx_data_valid <= 1'b1;
                    err_tx          <= 1'b0;
                    cnt             <= '0;
                    state           <= TRANSMIT;
                end

                TRANSMIT: begin
                    if (i_tx_ready) begin
                        if (err_tx || (cnt == LAST_LANE)) begin
                            o_tx_data_valid <= 1'b0;
                            err_tx          <= 1'b0;
                            o_busy          <= 1'b0;
                            state           <= IDLE;
                        end else begin
                            o_tx_data <= tx_next_byte;
                            cnt       <= cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_cmd_engine.md
# reg_cmd_engine

Parametrised UART register-access engine between the UART RX/TX byte interfaces and the register file. It decodes command bytes and assembles multi-byte write words. It issues single-cycle read/write strobes and serialises multi-byte read data back to TX with a valid/ready handshake. It adds address range checking and an inter-byte timeout.

## Interface
- DATA_BYTES, 1: register width in bytes; DATA_W = 8*DATA_BYTES.
- ADDR_W, 3: register address width, 1..7.
- NUM_REGS, 8: number of implemented registers, 1..2**ADDR_W.
- TIMEOUT, 100000: maximum idle cycles between write data bytes; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_data  in  8  received byte.
- i_rx_data_valid  in  1  one-cycle strobe, i_rx_data valid.
- o_tx_data  out  8  byte to transmit.
- o_tx_data_valid  out  1  TX byte valid; held until accepted.
- i_tx_ready  in  1  TX accepts the byte when valid&ready.
- o_rwaddr  out  ADDR_W  register address.
- o_rd_req  out  1  one-cycle read strobe.
- o_wr_req  out  1  one-cycle write strobe.
- o_write_reg  out  DATA_W  write data.
- i_read_reg  in  DATA_W  read data, valid the cycle after o_rd_req.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout  out  1  one-cycle pulse when a write is aborted.

## Operation
- Command byte fields:
  - bit0 = 1 is a write, 0 is a read.
  - bits[7:1] form the address field.
  - The address is in range when the field is < NUM_REGS; o_rwaddr takes field[ADDR_W-1:0].
- IDLE:
  - On i_rx_data_valid, latch op, address and the range flag; clear the byte counter.
  - Write goes to GET_DATA.
  - In-range read goes to READ_REQ.
  - Out-of-range read loads ERR_BYTE (8'hEE) as a single TX byte and goes to TRANSMIT.
- GET_DATA:
  - Each rx byte is stored at byte lane cnt, little-endian (first byte is the LSB); cnt increments.
  - On the byte where cnt == DATA_BYTES-1, go to WRITE_REG.
- WRITE_REG:
  - o_wr_req = 1 for exactly one cycle with o_write_reg = the assembled word, but only if the address is in range.
  - Out-of-range writes are silently dropped.
  - Next state is IDLE.
- READ_REQ: o_rd_req = 1 for one cycle, then READ_CAP.
- READ_CAP: capture i_read_reg into the TX shift register; cnt = 0; go to TRANSMIT.
- TRANSMIT:
  - o_tx_data_valid = 1 and o_tx_data = byte lane cnt (LSB first).
  - On valid&ready, advance to the next byte.
  - After the last byte (DATA_BYTES bytes, or 1 for the error byte), drop valid and go to IDLE.
- Timeout (GET_DATA only):
  - The counter clears on entry and on every accepted byte.
  - When it reaches TIMEOUT-1 with no byte, pulse o_timeout, discard partial data and go to IDLE; no o_wr_req.
- rx bytes arriving in READ_REQ, READ_CAP, TRANSMIT or WRITE_REG are dropped, not queued.
- o_rwaddr and o_write_reg hold their last values in IDLE.
- o_tx_data holds its last value after valid drops.

## Timing
- All outputs are registered.
- Reset values:
  - State is IDLE.
  - All outputs and all internal registers reset to 0.
- Asserting i_rst mid-transaction:
  - Aborts immediately; o_tx_data_valid drops asynchronously with reset.
  - No strobe is emitted after reset releases.
- Read, with the command strobe in cycle 0:
  - o_rd_req is high in cycle 1.
  - i_read_reg is sampled at the end of cycle 2.
  - o_tx_data_valid rises in cycle 3.
- Write: the last data byte strobe in cycle N gives o_wr_req high in cycle N+1; the engine is back in IDLE in cycle N+2.
- Back-to-back commands: a command byte arriving the cycle after return to IDLE is accepted.
- Handshake:
  - o_tx_data_valid never drops without acceptance.
  - o_tx_data is stable while valid&!ready.
- o_rd_req and o_wr_req are never high simultaneously.

## Structure
- uart_pkg gains:
  - the cmd_state_t enum (IDLE, GET_DATA, WRITE_REG, READ_REQ, READ_CAP, TRANSMIT);
  - ERR_BYTE = 8'hEE;
  - CMD_WR_BIT = 0.
- One sub-module, cmd_timeout_timer: parametrised down-counter with clear and expire outputs; it is tied off when TIMEOUT = 0.
- Byte counter width is $clog2(DATA_BYTES+1).

## Test plan
- Read, DATA_BYTES=4, i_read_reg = 32'hA1B2C3D4: rx 8'h04 -> o_rd_req once at addr 2; TX bytes D4, C3, B2, A1, with ready stalled 3 cycles on byte 2 and data held.
- Write: rx 8'h07, 78, 56, 34, 12 -> single o_wr_req with addr 3, o_write_reg = 32'h12345678, one cycle after the last byte.
- NUM_REGS=5: read cmd 8'h0C (addr 6) -> TX ERR_BYTE 8'hEE only, no o_rd_req; write cmd 8'h0D plus 4 bytes -> no o_wr_req.
- TIMEOUT=20: write cmd plus 2 bytes, then silence -> o_timeout pulses exactly 20 cycles after the last byte, no o_wr_req; the next read command works normally.
- i_rst asserted mid-TRANSMIT and in GET_DATA -> all outputs 0 immediately; after release, a full read/write sequence passes.
- rx byte injected during TRANSMIT -> ignored; the TX sequence is unchanged and no extra command is decoded.
